// File: rtl/diode_line_pkg.sv
// rtl/diode_line_pkg.sv - shared defaults, FSM state type and width helper for the diode line reader
package diode_line_pkg;

    localparam int DEFAULT_PIXELS     = 128;
    localparam int DEFAULT_DATA_W     = 12;
    localparam int DEFAULT_PIX_PERIOD = 4;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } line_state_t;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/diode_line_reader_if.sv
// rtl/diode_line_reader_if.sv - pixel sample stream from the reader to its consumer
interface diode_line_reader_if #(
    parameter int DATA_W = diode_line_pkg::DEFAULT_DATA_W
);
    logic [DATA_W-1:0] pix_data_o;
    logic              pix_valid_o;
    logic              pix_last_o;
    logic              pix_ready_i;

    modport master (output pix_data_o, output pix_valid_o, output pix_last_o, input pix_ready_i);
    modport slave  (input pix_data_o, input pix_valid_o, input pix_last_o, output pix_ready_i);
endinterface

// File: rtl/diode_line_fifo.sv
// rtl/diode_line_fifo.sv - show-ahead synchronous FIFO with one-bit-extended pointers
module diode_line_fifo import diode_line_pkg::*; #(
    parameter int WIDTH = 13,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk_10MHz_i,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             one_left
);
    localparam int AW = cnt_width(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one_left = ((wr_ptr - rd_ptr) == (AW+1)'(1));
    assign do_rd    = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write
    assign do_wr    = wr_en && (!full || do_rd);
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_10MHz_i) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/diode_line_reader.sv
// rtl/diode_line_reader.sv - clocks a photodiode line out pixel by pixel and buffers the ADC samples
module diode_line_reader import diode_line_pkg::*; #(
    parameter int PIXELS     = DEFAULT_PIXELS,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int PIX_PERIOD = DEFAULT_PIX_PERIOD,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk_10MHz_i,
    input  logic              reset_n,
    input  logic              signal_to_diods,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              diod_clk_o,
    output logic              line_busy_o,
    output logic              line_done_o,
    output logic              overflow_o,
    diode_line_reader_if.master pix
);
    localparam int             CW       = cnt_width(PIXELS);
    localparam int             PW       = cnt_width(PIX_PERIOD);
    localparam logic [CW-1:0]  LAST_PIX = CW'(PIXELS - 1);
    localparam logic [PW-1:0]  LAST_PH  = PW'(PIX_PERIOD - 1);

    line_state_t     state;
    line_state_t     state_nxt;
    logic            sig_q;
    logic            start;
    logic [CW-1:0]   pix_cnt;
    logic [PW-1:0]   phase;
    logic            sample;
    logic            sample_last;
    logic            rd_fire;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_one_left;
    logic [DATA_W:0] head;

    // End of integration is the falling edge of the exposure pulse
    assign start       = sig_q && !signal_to_diods;
    assign sample_last = (pix_cnt == LAST_PIX);
    assign rd_fire     = pix.pix_ready_i && !fifo_empty;

    always_ff @(posedge clk_10MHz_i) begin
        if (!reset_n) sig_q <= 1'b0;
        else          sig_q <= signal_to_diods;
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  if (sample && sample_last) state_nxt = ST_DRAIN;
            // Leave as soon as the final word is being taken, not a cycle later
            ST_DRAIN: if (fifo_empty || (rd_fire && fifo_one_left)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        diod_clk_o  = 1'b0;
        line_busy_o = 1'b0;
        line_done_o = 1'b0;
        sample      = 1'b0;
        case (state)
            ST_READ: begin
                line_busy_o = 1'b1;
                diod_clk_o  = (phase == '0);
                sample      = (phase == LAST_PH);
            end
            ST_DRAIN: line_busy_o = 1'b1;
            ST_DONE:  line_done_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (!reset_n) begin
            phase      <= '0;
            pix_cnt    <= '0;
            overflow_o <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                phase      <= '0;
                pix_cnt    <= '0;
                overflow_o <= 1'b0;
            end
        end else if (state == ST_READ) begin
            phase <= (phase == LAST_PH) ? '0 : phase + PW'(1);
            if (sample && !sample_last) pix_cnt <= pix_cnt + CW'(1);
            if (sample && fifo_full && !rd_fire) overflow_o <= 1'b1;
        end
    end

    diode_line_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_10MHz_i (clk_10MHz_i),
        .reset_n     (reset_n),
        .wr_en       (sample),
        .wr_data     ({sample_last, adc_data_i}),
        .rd_en       (pix.pix_ready_i),
        .rd_data     (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .one_left    (fifo_one_left)
    );

    assign pix.pix_valid_o = !fifo_empty;
    assign pix.pix_data_o  = head[DATA_W-1:0];
    assign pix.pix_last_o  = !fifo_empty && head[DATA_W];

endmodule
